// File: rtl/uart_stream_decoder.sv
// UART receive decoder with parity/framing checks and a first-word fall-through receive FIFO.
// Define UART_DECODER_MAJORITY_EN to take each bit as a 2-of-3 vote around the mid-bit sample.
module uart_stream_decoder #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_i,
  input  logic                          enable_i,
  input  logic                          rd_en_i,
  input  logic                          clr_err_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o,
  output logic                          valid_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          overflow_o,
  output logic                          busy_o
);

  localparam int unsigned CntW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned Mid    = CLKS_PER_BIT / 2;
  localparam int unsigned IdxW   = $clog2(DATA_BITS);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = DATA_BITS + 2;

  localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);
  localparam logic [PtrW:0]   DepthVal = FIFO_DEPTH[PtrW:0];
  localparam logic [PtrW:0]   CountOne = 1;

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop1, StStop2
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  sync1_q, rxs_q, rxs_prev_q;
  logic                  sample_now, sample_bit;
  logic                  cnt_last, par_xor, frm_now, push;
  logic [EntryW-1:0]     push_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync1_q    <= rx_i;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
    end
  end

`ifdef UART_DECODER_MAJORITY_EN
  localparam logic [CntW-1:0] SampleCnt = CntW'(Mid + 1);
  logic [1:0] maj_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj_q <= 2'b11;
    end else begin
      if (cnt_q == CntW'(Mid - 1)) maj_q[0] <= rxs_q;
      if (cnt_q == CntW'(Mid))     maj_q[1] <= rxs_q;
    end
  end

  // Vote is resolved one cycle after mid, once the third sample is on rxs_q.
  assign sample_bit = (maj_q[0] & maj_q[1]) | (maj_q[0] & rxs_q) | (maj_q[1] & rxs_q);
`else
  localparam logic [CntW-1:0] SampleCnt = CntW'(Mid);
  assign sample_bit = rxs_q;
`endif

  assign sample_now = (cnt_q == SampleCnt);
  assign cnt_last   = (cnt_q == CntLast);
  assign par_xor    = (^shift_q) ^ sample_bit;
  assign frm_now    = ferr_q | ~sample_bit;
  assign push_word  = {frm_now, perr_q, shift_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    push    = 1'b0;
    if (state_q != StIdle) begin
      cnt_d = cnt_last ? '0 : cnt_q + CntW'(1);
    end
    case (state_q)
      StIdle: begin
        if (enable_i && !rxs_q && rxs_prev_q) begin
          state_d = StStart;
          cnt_d   = '0;
          idx_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      StStart: begin
        if (sample_now && sample_bit) begin
          state_d = StIdle;
        end else if (cnt_last) begin
          state_d = StData;
        end
      end
      StData: begin
        if (sample_now) begin
          shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
        end
        if (cnt_last) begin
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop1;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (sample_now) begin
          perr_d = (PARITY == 1) ? ~par_xor : par_xor;
        end
        if (cnt_last) begin
          state_d = StStop1;
        end
      end
      StStop1: begin
        if (sample_now) begin
          ferr_d = frm_now;
          if (STOP_BITS == 1) begin
            push    = 1'b1;
            state_d = StIdle;
          end
        end
        if (STOP_BITS != 1 && cnt_last) begin
          state_d = StStop2;
        end
      end
      StStop2: begin
        // Leave at the sample point so back-to-back frames can resync.
        if (sample_now) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o = (state_q != StIdle);

  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              ovf_q;
  logic              full, pop, push_ok, drop;
  logic [EntryW-1:0] head;

  assign full    = (count_q == DepthVal);
  assign pop     = rd_en_i && (count_q != '0);
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CountOne;
        2'b01:   count_q <= count_q - CountOne;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (clr_err_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Head is gated by valid so outputs read zero when empty and straight out of reset.
  assign head         = mem_q[rd_ptr_q];
  assign valid_o      = (count_q != '0);
  assign data_o       = valid_o ? head[DATA_BITS-1:0] : '0;
  assign parity_err_o = valid_o & head[DATA_BITS];
  assign frame_err_o  = valid_o & head[DATA_BITS+1];
  assign count_o      = count_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_uart_stream_decoder.sv
// Randomised bench for uart_stream_decoder (8E1, 8 clocks per bit, 4-deep FIFO) against a
// frame-level model: expected words, push edges and busy windows are computed per frame.
module tb_uart_stream_decoder;

  localparam int C      = 8;
  localparam int MID    = C / 2;
  localparam int PAR    = 2;
  localparam int DEPTH  = 4;
  localparam int NBITS  = 11;
  localparam int FINAL  = NBITS - 1;
`ifdef UART_DECODER_MAJORITY_EN
  localparam int SAMP_OFF = 1;
`else
  localparam int SAMP_OFF = 0;
`endif

  logic       clk, rst_n, rx, enable, rd_en, clr_err;
  logic [7:0] data_o;
  logic       frame_err_o, parity_err_o, valid_o, overflow_o, busy_o;
  logic [2:0] count_o;

  uart_stream_decoder #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (8),
    .PARITY      (PAR),
    .STOP_BITS   (1),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (rx),
    .enable_i    (enable),
    .rd_en_i     (rd_en),
    .clr_err_i   (clr_err),
    .data_o      (data_o),
    .frame_err_o (frame_err_o),
    .parity_err_o(parity_err_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .overflow_o  (overflow_o),
    .busy_o      (busy_o)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         sched_edge = -1;
  logic [9:0] sched_word = '0;
  int         busy_lo = 0;
  int         busy_hi = 0;
  int         rd_pct = 0;
  int         clr_pct = 0;
  logic [9:0] q[$];
  logic       ovf_m = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: FIFO of {frame_err, parity_err, data}, updated on each rising edge.
  initial begin
    logic m_pop, m_push, m_drop;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!rst_n) begin
        q.delete();
        ovf_m = 1'b0;
      end else begin
        m_pop  = rd_en && (q.size() != 0);
        m_push = (cyc == sched_edge);
        m_drop = m_push && (q.size() == DEPTH) && !m_pop;
        if (m_pop) void'(q.pop_front());
        if (m_push && !m_drop) q.push_back(sched_word);
        if (m_drop) ovf_m = 1'b1;
        else if (clr_err) ovf_m = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_cycle();
    logic [9:0] h;
    int         n;
    logic       ov, bz;
    h  = '0;
    n  = 0;
    ov = 1'b0;
    bz = 1'b0;
    if (rst_n) begin
      n  = q.size();
      h  = (n > 0) ? q[0] : '0;
      ov = ovf_m;
      bz = (cyc >= busy_lo) && (cyc < busy_hi);
    end
    chk("count", 32'(count_o), 32'(n));
    chk("valid", 32'(valid_o), 32'(n > 0));
    chk("data", 32'(data_o), 32'(h[7:0]));
    chk("parity_err", 32'(parity_err_o), 32'(h[8]));
    chk("frame_err", 32'(frame_err_o), 32'(h[9]));
    chk("overflow", 32'(overflow_o), 32'(ov));
    chk("busy", 32'(busy_o), 32'(bz));
  endtask

  task automatic cycle(input logic rx_v, input bit force_pop, input bit force_clr);
    rx      = rx_v;
    rd_en   = force_pop || (rd_pct != 0 && $urandom_range(99) < rd_pct);
    clr_err = force_clr || (clr_pct != 0 && $urandom_range(99) < clr_pct);
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int glitch_k, input int rst_at, input int en_off_at,
                            input bit pop_at_push, input int gap);
    int          e0, push_e, k;
    logic [10:0] bits;
    logic [7:0]  d_rx;
    logic        xr, v;
    e0     = cyc;
    push_e = e0 + 4 + FINAL * C + MID + SAMP_OFF;
    bits   = {stop, par, d, 1'b0};
    d_rx   = d;
`ifndef UART_DECODER_MAJORITY_EN
    if (glitch_k >= 0) d_rx[glitch_k] = ~d_rx[glitch_k];
`endif
    xr = (^d_rx) ^ par;
    if (enable) begin
      sched_word = {~stop, (PAR == 1) ? ~xr : xr, d_rx};
      sched_edge = push_e;
      busy_lo    = e0 + 3;
      busy_hi    = push_e;
    end else begin
      sched_edge = -1;
      busy_lo    = 0;
      busy_hi    = 0;
    end
    for (int t = 0; t < NBITS * C + gap; t++) begin
      if (t == rst_at) begin
        rst_n      = 1'b0;
        rx         = 1'b1;
        rd_en      = 1'b0;
        clr_err    = 1'b0;
        sched_edge = -1;
        busy_hi    = 0;
        #1;
        chk("reset_busy_now", 32'(busy_o), 32'd0);
        chk("reset_count_now", 32'(count_o), 32'd0);
        check_cycle();
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        return;
      end
      if (t == en_off_at) enable = 1'b0;
      k = t / C;
      v = (k < NBITS) ? bits[k] : 1'b1;
      if (glitch_k >= 0 && t == 1 + (glitch_k + 1) * C + MID) v = ~v;
      cycle(v, pop_at_push && (e0 + t + 1 == push_e), 1'b0);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic stop);
    send_frame(d, par, stop, -1, -1, -1, 1'b0, 4);
  endtask

  task automatic pulse(input int len);
    int e0;
    e0         = cyc;
    sched_edge = -1;
    busy_lo    = e0 + 3;
    busy_hi    = e0 + 4 + MID + SAMP_OFF;
    repeat (len) cycle(1'b0, 1'b0, 1'b0);
    repeat (2 * C) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    rst_n   = 1'b0;
    rx      = 1'b1;
    enable  = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    #2;
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_data", 32'(data_o), 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 1'b0);

    // Basic decode
    send(8'h55, 1'b0, 1'b1);
    chk("basic_count1", 32'(count_o), 32'd1);
    chk("basic_head55", 32'(data_o), 32'h55);
    send(8'hA3, 1'b0, 1'b1);
    chk("basic_count2", 32'(count_o), 32'd2);
    chk("basic_still55", 32'(data_o), 32'h55);
    cycle(1'b1, 1'b1, 1'b0);
    chk("basic_headA3", 32'(data_o), 32'hA3);
    chk("basic_perrA3", 32'(parity_err_o), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("basic_empty", 32'(valid_o), 32'd0);

    // Even parity on 0x07
    send(8'h07, 1'b1, 1'b1);
    chk("par_ok", 32'(parity_err_o), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    send(8'h07, 1'b0, 1'b1);
    chk("par_bad", 32'(parity_err_o), 32'd1);
    chk("par_bad_data", 32'(data_o), 32'h07);
    cycle(1'b1, 1'b1, 1'b0);

    // Framing error then false start
    send(8'h3C, 1'b0, 1'b0);
    chk("frm_err", 32'(frame_err_o), 32'd1);
    chk("frm_data", 32'(data_o), 32'h3C);
    cycle(1'b1, 1'b1, 1'b0);
    pulse(2);
    chk("false_start_count", 32'(count_o), 32'd0);
    chk("false_start_busy", 32'(busy_o), 32'd0);

    // Overflow, pop-while-full, clear
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    send(8'h44, 1'b0, 1'b1);
    send(8'h5A, 1'b0, 1'b1);
    chk("ovf_count", 32'(count_o), 32'd4);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_head", 32'(data_o), 32'h11);
    send_frame(8'h66, 1'b0, 1'b1, -1, -1, -1, 1'b1, 4);
    chk("full_pop_count", 32'(count_o), 32'd4);
    chk("full_pop_head", 32'(data_o), 32'h22);
    cycle(1'b1, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow_o), 32'd0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("drain_head33", 32'(data_o), 32'h33);
    repeat (3) cycle(1'b1, 1'b1, 1'b0);
    chk("drain_last", 32'(count_o), 32'd0);

    // Reset mid-DATA, then a clean frame
    send_frame(8'h5A, 1'b0, 1'b1, -1, 3 * C, -1, 1'b0, 4);
    repeat (2) cycle(1'b1, 1'b0, 1'b0);
    send(8'h81, 1'b0, 1'b1);
    chk("post_reset_data", 32'(data_o), 32'h81);
    chk("post_reset_count", 32'(count_o), 32'd1);
    cycle(1'b1, 1'b1, 1'b0);

    // Enable dropped mid-frame
    send_frame(8'h42, 1'b0, 1'b1, -1, -1, 4 * C, 1'b0, 4);
    send(8'h24, 1'b0, 1'b1);
    chk("en_count", 32'(count_o), 32'd1);
    chk("en_head", 32'(data_o), 32'h42);
    enable = 1'b1;
    cycle(1'b1, 1'b1, 1'b0);

    // One-cycle glitch at the bit-3 sample point
    send_frame(8'h00, 1'b0, 1'b1, 3, -1, -1, 1'b0, 4);
`ifdef UART_DECODER_MAJORITY_EN
    chk("glitch_data", 32'(data_o), 32'h00);
    chk("glitch_perr", 32'(parity_err_o), 32'd0);
`else
    chk("glitch_data", 32'(data_o), 32'h08);
    chk("glitch_perr", 32'(parity_err_o), 32'd1);
`endif
    cycle(1'b1, 1'b1, 1'b0);

    // Random traffic with random reads and clears
    rd_pct  = 30;
    clr_pct = 3;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      send_frame(d, (^d) ^ ($urandom_range(3) == 0), $urandom_range(7) != 0,
                 -1, -1, -1, 1'b0, $urandom_range(12, 2));
    end
    rd_pct  = 100;
    clr_pct = 0;
    repeat (8) cycle(1'b1, 1'b0, 1'b0);
    chk("final_empty", 32'(count_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
